// File: rtl/bsg_print_stat_pkg.sv
// bsg_print_stat_pkg: shared tag field layout, tag types and output record format
// for print-stat snoop consumers.
package bsg_print_stat_pkg;

    typedef enum logic [1:0] {
        e_stat   = 2'd0,
        e_start  = 2'd1,
        e_end    = 2'd2,
        e_kernel = 2'd3
    } tag_type_e;

    localparam int type_hi_lp     = 31;
    localparam int type_lo_lp     = 30;
    localparam int tg_id_hi_lp    = 29;
    localparam int tg_id_lo_lp    = 16;
    localparam int tag_hi_lp      = 3;
    localparam int tag_lo_lp      = 0;
    localparam int tg_id_width_lp = 14;
    localparam int tag_width_lp   = 4;
    localparam int ctr_width_lp   = 64;

    typedef struct packed {
        tag_type_e                 rtype;
        logic [tg_id_width_lp-1:0] tg_id;
        logic [tag_width_lp-1:0]   tag;
        logic [ctr_width_lp-1:0]   cycles;
    } record_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: register-based circular FIFO; full_o comes from registered
// occupancy only, so a pop in the same cycle never frees space for a push.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wptr, r_rptr;
    logic [cnt_w_lp-1:0] r_cnt;
    logic                w_enq, w_deq;

    assign full_o = (r_cnt == cnt_w_lp'(els_p));
    assign v_o    = (r_cnt != '0);
    assign data_o = r_mem[r_rptr];
    assign w_enq  = v_i & ~full_o;
    assign w_deq  = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_enq) r_wptr <= (r_wptr == ptr_w_lp'(els_p - 1)) ? '0 : r_wptr + 1'b1;
            if (w_deq) r_rptr <= (r_rptr == ptr_w_lp'(els_p - 1)) ? '0 : r_rptr + 1'b1;
            r_cnt <= r_cnt + cnt_w_lp'(w_enq) - cnt_w_lp'(w_deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_print_stat_tracker.sv
// bsg_print_stat_tracker: pairs START/END print-stat tags per tag id, queues timing records.
// Define BSG_PRINT_STAT_TRACKER_DISPLAY_EN for simulation-only $display tracing.
module bsg_print_stat_tracker
    import bsg_print_stat_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int ctr_width_p  = 64,
    parameter int tag_els_p    = 16,
    parameter int fifo_els_p   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   print_stat_v_i,
    input  logic [data_width_p-1:0] print_stat_tag_i,
    input  logic [ctr_width_p-1:0] global_ctr_i,
    output logic                   v_o,
    input  logic                   ready_i,
    output logic [1:0]             type_o,
    output logic [13:0]            tg_id_o,
    output logic [3:0]             tag_o,
    output logic [ctr_width_p-1:0] cycles_o,
    output logic [15:0]            drop_count_o,
    output logic [15:0]            mismatch_count_o
);
    logic                      r_v;
    tag_type_e                 r_type;
    logic [tg_id_width_lp-1:0] r_tg_id;
    logic [tag_width_lp-1:0]   r_tag;
    logic [ctr_width_p-1:0]    r_ctr;
    logic [tag_els_p-1:0]      r_open;
    logic [ctr_width_p-1:0]    r_start [tag_els_p];
    logic [15:0]               r_drop, r_mismatch;

    logic                   w_open, w_push, w_mismatch, w_full, w_drop;
    logic [ctr_width_p-1:0] w_cycles;
    record_s                w_rec, w_out;
    logic                   w_unused;

    assign w_unused = ^print_stat_tag_i[tg_id_lo_lp-1:tag_hi_lp+1];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_v <= 1'b0;
        end else begin
            r_v <= print_stat_v_i;
            if (print_stat_v_i) begin
                r_type  <= tag_type_e'(print_stat_tag_i[type_hi_lp:type_lo_lp]);
                r_tg_id <= print_stat_tag_i[tg_id_hi_lp:tg_id_lo_lp];
                r_tag   <= print_stat_tag_i[tag_hi_lp:tag_lo_lp];
                r_ctr   <= global_ctr_i;
            end
        end
    end

    // Subtraction wraps modulo 2^ctr_width_p, so a counter rollover still yields the true span.
    assign w_open     = r_open[r_tag];
    assign w_push     = r_v & ((r_type == e_end) ? w_open : (r_type != e_start));
    assign w_mismatch = r_v & ((r_type == e_start) ? w_open : ((r_type == e_end) & ~w_open));
    assign w_cycles   = (r_type == e_end) ? r_ctr - r_start[r_tag] : r_ctr;
    assign w_drop     = w_push & w_full;
    assign w_rec      = '{rtype: r_type, tg_id: r_tg_id, tag: r_tag, cycles: ctr_width_lp'(w_cycles)};

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_open     <= '0;
            r_drop     <= '0;
            r_mismatch <= '0;
        end else begin
            if (r_v && r_type == e_start) r_open[r_tag] <= 1'b1;
            else if (r_v && r_type == e_end) r_open[r_tag] <= 1'b0;
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            if (w_mismatch && r_mismatch != 16'hFFFF) r_mismatch <= r_mismatch + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_v && r_type == e_start) r_start[r_tag] <= r_ctr;
    end

    bsg_fifo_1r1w_small #(
        .width_p($bits(record_s)),
        .els_p  (fifo_els_p)
    ) fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (w_push),
        .data_i   (w_rec),
        .full_o   (w_full),
        .v_o      (v_o),
        .data_o   (w_out),
        .yumi_i   (ready_i)
    );

    assign type_o           = w_out.rtype;
    assign tg_id_o          = w_out.tg_id;
    assign tag_o            = w_out.tag;
    assign cycles_o         = w_out.cycles[ctr_width_p-1:0];
    assign drop_count_o     = r_drop;
    assign mismatch_count_o = r_mismatch;

`ifdef BSG_PRINT_STAT_TRACKER_DISPLAY_EN
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            if (w_push && !w_full)
                $display("print_stat: type=%0d tg_id=%0h tag=%0d cycles=%0d", r_type, r_tg_id, r_tag, w_cycles);
            if (w_drop) $display("print_stat: drop tag=%0d", r_tag);
            if (w_mismatch) $display("print_stat: mismatch tag=%0d", r_tag);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_print_stat_tracker.sv
// tb_bsg_print_stat_tracker: directed checks of START/END pairing, wrap, mismatch,
// drop, back-to-back pairing and reset flush.
module tb_bsg_print_stat_tracker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ev_v = 1'b0;
    logic [31:0] ev_tag = '0;
    logic [63:0] ctr = '0;
    logic        v, ready = 1'b0;
    logic [1:0]  rtype;
    logic [13:0] tg_id;
    logic [3:0]  tag;
    logic [63:0] cycles;
    logic [15:0] drops, mism;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    bsg_print_stat_tracker dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .print_stat_v_i  (ev_v),
        .print_stat_tag_i(ev_tag),
        .global_ctr_i    (ctr),
        .v_o             (v),
        .ready_i         (ready),
        .type_o          (rtype),
        .tg_id_o         (tg_id),
        .tag_o           (tag),
        .cycles_o        (cycles),
        .drop_count_o    (drops),
        .mismatch_count_o(mism)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [1:0] t, input logic [13:0] g, input logic [3:0] id, input logic [63:0] c);
        ev_v   = 1'b1;
        ev_tag = {t, g, 12'h0, id};
        ctr    = c;
        tick();
        ev_v   = 1'b0;
    endtask

    task automatic pop();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_v", 64'(v), 64'd0);
        chk("reset_drop", 64'(drops), 64'd0);
        chk("reset_mism", 64'(mism), 64'd0);
        reset_n = 1'b1;
        tick();

        ev(2'd1, 14'd0, 4'd3, 64'd100);
        ev(2'd2, 14'd0, 4'd3, 64'd250);
        chk("pair_v_early", 64'(v), 64'd0);
        tick();
        chk("pair_v", 64'(v), 64'd1);
        chk("pair_type", 64'(rtype), 64'd2);
        chk("pair_tag", 64'(tag), 64'd3);
        chk("pair_cycles", cycles, 64'd150);
        chk("pair_mism", 64'(mism), 64'd0);
        pop();
        chk("pair_popped", 64'(v), 64'd0);

        ev(2'd1, 14'd0, 4'd5, 64'hFFFF_FFFF_FFFF_FFF6);
        ev(2'd2, 14'd0, 4'd5, 64'd20);
        tick();
        chk("wrap_v", 64'(v), 64'd1);
        chk("wrap_cycles", cycles, 64'd30);
        pop();

        ev(2'd2, 14'd0, 4'd7, 64'd300);
        ev(2'd1, 14'd0, 4'd7, 64'd301);
        ev(2'd1, 14'd0, 4'd7, 64'd302);
        tick();
        chk("mism_v", 64'(v), 64'd0);
        chk("mism_count", 64'(mism), 64'd2);

        for (int i = 0; i < 10; i++) ev(2'd0, 14'(i), 4'd9, 64'(1000 + i));
        tick();
        chk("drop_count", 64'(drops), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("fill_v", 64'(v), 64'd1);
            chk("fill_type", 64'(rtype), 64'd0);
            chk("fill_tg", 64'(tg_id), 64'(i));
            chk("fill_cycles", cycles, 64'(1000 + i));
            tick();
            chk("stall_cycles", cycles, 64'(1000 + i));
            pop();
        end
        chk("fill_empty", 64'(v), 64'd0);

        ev(2'd1, 14'd0, 4'd1, 64'd500);
        ev(2'd2, 14'd0, 4'd1, 64'd501);
        tick();
        chk("b2b_v", 64'(v), 64'd1);
        chk("b2b_cycles", cycles, 64'd1);
        pop();
        ev(2'd0, 14'h2A, 4'd0, 64'd777);
        tick();
        chk("stat_tg", 64'(tg_id), 64'h2A);
        chk("stat_type", 64'(rtype), 64'd0);
        chk("stat_cycles", cycles, 64'd777);
        pop();

        ev(2'd1, 14'd0, 4'd2, 64'd10);
        for (int i = 0; i < 3; i++) ev(2'd3, 14'd0, 4'd0, 64'(20 + i));
        tick();
        chk("preflush_v", 64'(v), 64'd1);
        chk("preflush_type", 64'(rtype), 64'd3);
        reset_n = 1'b0;
        ready   = 1'b1;
        tick();
        ready   = 1'b0;
        reset_n = 1'b1;
        chk("flush_v", 64'(v), 64'd0);
        chk("flush_mism", 64'(mism), 64'd0);
        chk("flush_drop", 64'(drops), 64'd0);
        ev(2'd2, 14'd0, 4'd2, 64'd40);
        tick();
        tick();
        chk("flush_end_v", 64'(v), 64'd0);
        chk("flush_end_mism", 64'(mism), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bsg_print_stat_tracker.md
# bsg_print_stat_tracker

Timing consumer for print-stat events: sits directly downstream of `bsg_print_stat_snoop` in the replicant testbench top and takes its `print_stat_v`/`print_stat_tag` outputs plus the global cycle counter. It pairs START/END tags per tag id and measures elapsed cycles. It queues one record per event for a host/DPI reader over a valid/ready interface, and keeps drop and mismatch counters.

## Interface
- `data_width_p`, 32: width of `print_stat_tag_i`; must be 32.
- `ctr_width_p`, 64: width of the global counter and of elapsed-cycle results.
- `tag_els_p`, 16: number of tag slots; must equal 2^tag field width (4).
- `fifo_els_p`, 8: output record FIFO depth, ≥2.
- `clk_i` in 1: single clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `print_stat_v_i` in 1: event valid from snoop; no backpressure.
- `print_stat_tag_i` in data_width_p: event tag.
- `global_ctr_i` in ctr_width_p: free-running cycle counter.
- `v_o` out 1: record valid.
- `ready_i` in 1: consumer accepts record.
- `type_o` out 2: record type.
- `tg_id_o` out 14: tile-group id.
- `tag_o` out 4: tag id.
- `cycles_o` out ctr_width_p: elapsed cycles (END) or timestamp (STAT/KERNEL).
- `drop_count_o` out 16: records lost to full FIFO, saturating.
- `mismatch_count_o` out 16: unmatched START/END events, saturating.

## Operation
- Tag decode: [31:30] type (0 STAT, 1 START, 2 END, 3 KERNEL), [29:16] tg_id, [15:4] ignored, [3:0] tag.
- Stage 1 (input reg): on `print_stat_v_i`, capture tag and `global_ctr_i`. Accepts every cycle, back-to-back.
- Stage 2 (process): reads the slot table combinationally from stage-1 contents, updates it at the next edge, and produces at most one FIFO push.
- Slot table: per tag, `open` bit plus `start` timestamp (ctr_width_p).
  - START, slot closed: store start, set open, no push.
  - START, slot open: overwrite start, mismatch++, no push.
  - END, slot open: push record with cycles = ctr − start, modulo 2^ctr_width_p, so counter wrap is correct. Clear open.
  - END, slot closed: mismatch++, no push.
  - STAT/KERNEL: push record with cycles = captured ctr; table unchanged.
- Push when FIFO full: record dropped, drop_count++. Fullness is evaluated from the current registered state, so a same-cycle pop does not rescue the push.
- Counters saturate at 16'hFFFF.
- Slots are indexed by tag only. tg_id is carried in the record but is not part of matching.

## Timing
- Reset (`reset_n_i`=0 at edge) values:
  - `v_o`=0, both counters 0, all `open` bits 0, FIFO empty.
  - `type_o`/`tg_id_o`/`tag_o`/`cycles_o` don't-care while `v_o`=0.
- Reset mid-operation flushes queued records and in-flight stage-1 data. It applies on the next edge regardless of `ready_i`.
- Latency: event sampled at edge k → table/FIFO updated at edge k+1 → `v_o`=1 during cycle after edge k+1 (FIFO empty, no stall).
- Consecutive START then END on the same tag (edges k, k+1): END sees the open slot and yields cycles=1.
- Handshake: record transfers when `v_o & ready_i` at the edge. Outputs are stable while `v_o & ~ready_i`.
- Throughput: one push and one pop per cycle.

## Configuration
- `BSG_PRINT_STAT_TRACKER_DISPLAY_EN`
  - Defined: a nonsynthesizable `$display` of type, tg_id, tag and cycles on every successful push, and of "drop"/"mismatch" on those events.
  - Undefined: no display code; functional behaviour identical.

## Structure
- Package `bsg_print_stat_pkg`:
  - tag-type enum (STAT/START/END/KERNEL);
  - field position/width localparams;
  - packed record struct {type, tg_id, tag, cycles}.
  - `bsg_print_stat_snoop` consumers share this package.
- Sub-module: `bsg_fifo_1r1w_small` (width = record struct, els = fifo_els_p) for the output queue. Slot table and counters are local.

## Test plan
- START tag 3 at ctr 100, END tag 3 at ctr 250 → one record type=2, tag=3, cycles=150; mismatch 0.
- START tag 5 at ctr 2^64−10, END at ctr 20 → cycles=30 (wrap).
- END tag 7 with no START; then START 7 twice → no records, mismatch_count_o=2.
- `ready_i`=0, 10 STAT events back-to-back with fifo_els_p=8 → 8 records retained, in order, with correct timestamps; drop_count_o=2.
- START/END tag 1 at consecutive edges → cycles=1; STAT tg_id=0x2A → tg_id_o=0x2A, cycles=timestamp.
- Assert reset with 3 records queued and tag 2 open; release, END tag 2 → `v_o`=0 after reset, mismatch_count_o=1, no record.
